// File: rtl/axilite_pkg.sv
// Shared types and default widths for the AXI-Lite initiator bridge.
package axilite_pkg;

    localparam int AXI_ADDR_W = 12;
    localparam int AXI_DATA_W = 32;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ADDR,
        W_DATA,
        W_DONE
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ADDR,
        R_DATA,
        R_DONE
    } rd_state_e;

endpackage

// File: rtl/axilite_req_slot.sv
// One-deep request holding register. A push is stored when the slot is empty
// or is being popped in the same cycle; otherwise it is dropped and the sticky
// overflow flag is set.
module axilite_req_slot #(
    parameter int W = 8
) (
    input  logic         axi_aclk,
    input  logic         axi_aresetn,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic         full_o,
    output logic [W-1:0] data_o,
    output logic         overflow_o
);

    logic         full_q, full_d;
    logic [W-1:0] data_q, data_d;
    logic         ovf_q, ovf_d;
    logic         accept;

    // Next-state: store, release, or flag a dropped request.
    always_comb begin
        accept = push_i && (!full_q || pop_i);
        full_d = full_q;
        data_d = data_q;
        ovf_d  = ovf_q;
        if (accept) begin
            full_d = 1'b1;
            data_d = data_i;
        end else if (pop_i) begin
            full_d = 1'b0;
        end
        if (push_i && !accept) ovf_d = 1'b1;
    end

    // Slot state registers.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            full_q <= 1'b0;
            data_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
            ovf_q  <= ovf_d;
        end
    end

    assign full_o     = full_q;
    assign data_o     = data_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/axilite_master.sv
// Backend-to-AXI-Lite bridge: independent posted-write and read channels,
// each with a one-deep pending slot for requests arriving while busy.
module axilite_master
    import axilite_pkg::*;
#(
    parameter int ADDR_WIDTH = AXI_ADDR_W,
    parameter int DATA_WIDTH = AXI_DATA_W
) (
    input  logic                    axi_aclk,
    input  logic                    axi_aresetn,
    input  logic                    bk_wstart,
    input  logic [ADDR_WIDTH-1:0]   bk_waddr,
    input  logic [DATA_WIDTH-1:0]   bk_wdata,
    input  logic [DATA_WIDTH/8-1:0] bk_wstrb,
    output logic                    bk_wdone,
    input  logic                    bk_rstart,
    input  logic [ADDR_WIDTH-1:0]   bk_raddr,
    output logic [DATA_WIDTH-1:0]   bk_rdata,
    output logic                    bk_rdone,
    output logic                    wr_overflow,
    output logic                    rd_overflow,
    output logic                    axi_awvalid,
    output logic [ADDR_WIDTH-1:0]   axi_awaddr,
    input  logic                    axi_awready,
    output logic                    axi_wvalid,
    output logic [DATA_WIDTH-1:0]   axi_wdata,
    output logic [DATA_WIDTH/8-1:0] axi_wstrb,
    input  logic                    axi_wready,
    output logic                    axi_arvalid,
    output logic [ADDR_WIDTH-1:0]   axi_araddr,
    input  logic                    axi_arready,
    input  logic                    axi_rvalid,
    input  logic [DATA_WIDTH-1:0]   axi_rdata,
    output logic                    axi_rready
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int WPL_W  = ADDR_WIDTH + DATA_WIDTH + STRB_W;

    // ---------------- write channel ----------------
    wr_state_e               w_state_q, w_state_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]       wstrb_q, wstrb_d;
    logic                    wdone_q;
    logic                    w_launch, w_direct, wslot_full, wslot_pop;
    logic [WPL_W-1:0]        wslot_dout;

    // A request may go straight to the bus when idle, or when finishing with
    // nothing pending; any other request is offered to the slot.
    assign w_launch  = (w_state_q == W_IDLE) || (w_state_q == W_DONE);
    assign w_direct  = bk_wstart && w_launch && !wslot_full;
    assign wslot_pop = (w_state_q == W_DONE) && wslot_full;

    axilite_req_slot #(.W(WPL_W)) u_wslot (
        .axi_aclk    (axi_aclk),
        .axi_aresetn (axi_aresetn),
        .push_i      (bk_wstart && !w_direct),
        .pop_i       (wslot_pop),
        .data_i      ({bk_waddr, bk_wdata, bk_wstrb}),
        .full_o      (wslot_full),
        .data_o      (wslot_dout),
        .overflow_o  (wr_overflow)
    );

    // Write FSM: AW then W strictly in sequence; pending slot takes priority.
    always_comb begin
        w_state_d = w_state_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        case (w_state_q)
            W_IDLE: if (w_direct) begin
                awaddr_d  = bk_waddr;
                wdata_d   = bk_wdata;
                wstrb_d   = bk_wstrb;
                w_state_d = W_ADDR;
            end
            W_ADDR: if (axi_awready) w_state_d = W_DATA;
            W_DATA: if (axi_wready)  w_state_d = W_DONE;
            W_DONE: begin
                if (wslot_full) begin
                    {awaddr_d, wdata_d, wstrb_d} = wslot_dout;
                    w_state_d = W_ADDR;
                end else if (w_direct) begin
                    awaddr_d  = bk_waddr;
                    wdata_d   = bk_wdata;
                    wstrb_d   = bk_wstrb;
                    w_state_d = W_ADDR;
                end else begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write state/payload registers; done pulse follows the W_DONE cycle.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            w_state_q <= W_IDLE;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            wdone_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            wdone_q   <= (w_state_q == W_DONE);
        end
    end

    assign axi_awvalid = (w_state_q == W_ADDR);
    assign axi_wvalid  = (w_state_q == W_DATA);
    assign axi_awaddr  = awaddr_q;
    assign axi_wdata   = wdata_q;
    assign axi_wstrb   = wstrb_q;
    assign bk_wdone    = wdone_q;

    // ---------------- read channel ----------------
    rd_state_e               r_state_q, r_state_d;
    logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    r_launch, r_direct, rslot_full, rslot_pop;
    logic [ADDR_WIDTH-1:0]   rslot_dout;

    assign r_launch  = (r_state_q == R_IDLE) || (r_state_q == R_DONE);
    assign r_direct  = bk_rstart && r_launch && !rslot_full;
    assign rslot_pop = (r_state_q == R_DONE) && rslot_full;

    axilite_req_slot #(.W(ADDR_WIDTH)) u_rslot (
        .axi_aclk    (axi_aclk),
        .axi_aresetn (axi_aresetn),
        .push_i      (bk_rstart && !r_direct),
        .pop_i       (rslot_pop),
        .data_i      (bk_raddr),
        .full_o      (rslot_full),
        .data_o      (rslot_dout),
        .overflow_o  (rd_overflow)
    );

    // Read FSM: AR handshake, then wait for R and capture the data.
    always_comb begin
        r_state_d = r_state_q;
        araddr_d  = araddr_q;
        rdata_d   = rdata_q;
        case (r_state_q)
            R_IDLE: if (r_direct) begin
                araddr_d  = bk_raddr;
                r_state_d = R_ADDR;
            end
            R_ADDR: if (axi_arready) r_state_d = R_DATA;
            R_DATA: if (axi_rvalid) begin
                rdata_d   = axi_rdata;
                r_state_d = R_DONE;
            end
            R_DONE: begin
                if (rslot_full) begin
                    araddr_d  = rslot_dout;
                    r_state_d = R_ADDR;
                end else if (r_direct) begin
                    araddr_d  = bk_raddr;
                    r_state_d = R_ADDR;
                end else begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read state/payload registers.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_state_q <= R_IDLE;
            araddr_q  <= '0;
            rdata_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            araddr_q  <= araddr_d;
            rdata_q   <= rdata_d;
        end
    end

    assign axi_arvalid = (r_state_q == R_ADDR);
    assign axi_rready  = (r_state_q == R_DATA);
    assign axi_araddr  = araddr_q;
    assign bk_rdata    = rdata_q;
    assign bk_rdone    = (r_state_q == R_DONE);

endmodule

// File: tb/tb_axilite_master.sv
// Directed, table-driven bench for axilite_master with a stall-programmable
// AXI-Lite slave model.
module tb_axilite_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bk_wstart, bk_rstart;
    logic [11:0] bk_waddr, bk_raddr;
    logic [31:0] bk_wdata;
    logic [3:0]  bk_wstrb;
    logic        bk_wdone, bk_rdone, wr_overflow, rd_overflow;
    logic [31:0] bk_rdata;
    logic        awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;
    logic [11:0] awaddr, araddr;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;

    int checks = 0;
    int failures = 0;

    // slave configuration and logs
    int          aw_st = 0, w_st = 0, ar_st = 0, r_st = 0;
    int          aw_cnt, w_cnt, ar_cnt, r_cnt;
    logic [31:0] slv_rdata = '0;
    logic [11:0] aw_log [32];
    logic [31:0] wd_log [32];
    logic [3:0]  ws_log [32];
    logic [11:0] ar_log [32];
    int          aw_n = 0, w_n = 0, ar_n = 0;

    always #5 clk = ~clk;

    axilite_master dut (
        .axi_aclk(clk), .axi_aresetn(rst_n),
        .bk_wstart(bk_wstart), .bk_waddr(bk_waddr), .bk_wdata(bk_wdata), .bk_wstrb(bk_wstrb),
        .bk_wdone(bk_wdone), .bk_rstart(bk_rstart), .bk_raddr(bk_raddr), .bk_rdata(bk_rdata),
        .bk_rdone(bk_rdone), .wr_overflow(wr_overflow), .rd_overflow(rd_overflow),
        .axi_awvalid(awvalid), .axi_awaddr(awaddr), .axi_awready(awready),
        .axi_wvalid(wvalid), .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wready(wready),
        .axi_arvalid(arvalid), .axi_araddr(araddr), .axi_arready(arready),
        .axi_rvalid(rvalid), .axi_rdata(rdata), .axi_rready(rready)
    );

    assign awready = awvalid && (aw_cnt >= aw_st);
    assign wready  = wvalid  && (w_cnt  >= w_st);
    assign arready = arvalid && (ar_cnt >= ar_st);
    assign rvalid  = rready  && (r_cnt  >= r_st);
    assign rdata   = slv_rdata;

    // Stall counters: count cycles a valid (or rready) has waited.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
        end else begin
            aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (wvalid  && !wready)  ? w_cnt  + 1 : 0;
            ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
            r_cnt  <= (rready  && !rvalid)  ? r_cnt  + 1 : 0;
        end
    end

    // Handshake logs seen by the slave.
    always @(posedge clk) begin
        if (awvalid && awready) begin aw_log[aw_n % 32] <= awaddr; aw_n <= aw_n + 1; end
        if (wvalid && wready) begin
            wd_log[w_n % 32] <= wdata; ws_log[w_n % 32] <= wstrb; w_n <= w_n + 1;
        end
        if (arvalid && arready) begin ar_log[ar_n % 32] <= araddr; ar_n <= ar_n + 1; end
    end

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          st_a;   // AW or AR stall cycles
        int          st_d;   // W or R stall cycles
    } vec_t;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_write(input vec_t v);
        int n, first_aw, first_w, bad, base;
        logic done;
        aw_st = v.st_a; w_st = v.st_d; base = aw_n;
        bk_wstart = 1'b1; bk_waddr = v.addr; bk_wdata = v.data; bk_wstrb = v.strb;
        tick;
        bk_wstart = 1'b0;
        n = 1; first_aw = -1; first_w = -1; bad = 0; done = 1'b0;
        while (n < 60) begin
            if (awvalid && first_aw < 0) first_aw = n;
            if (wvalid && first_w < 0) first_w = n;
            if (awvalid && awaddr !== v.addr) bad++;
            if (wvalid && (wdata !== v.data || wstrb !== v.strb)) bad++;
            if (awvalid && wvalid) bad++;
            if (bk_wdone) begin done = 1'b1; break; end
            tick;
            n++;
        end
        chk("wr_done_seen", 64'(done), 64'd1);
        chk("wr_latency", 64'(n), 64'(4 + v.st_a + v.st_d));
        chk("wr_awvalid_cycle", 64'(first_aw), 64'd1);
        chk("wr_wvalid_cycle", 64'(first_w), 64'(2 + v.st_a));
        chk("wr_payload_stable", 64'(bad), 64'd0);
        chk("wr_slave_addr", 64'(aw_log[base % 32]), 64'(v.addr));
        chk("wr_slave_data", 64'({ws_log[base % 32], wd_log[base % 32]}), 64'({v.strb, v.data}));
        tick;
        chk("wr_done_single", 64'(bk_wdone), 64'd0);
    endtask

    task automatic do_read(input vec_t v);
        int n, bad;
        logic done, ar_seen;
        ar_st = v.st_a; r_st = v.st_d; slv_rdata = v.data;
        bk_rstart = 1'b1; bk_raddr = v.addr;
        tick;
        bk_rstart = 1'b0;
        n = 1; bad = 0; done = 1'b0; ar_seen = 1'b0;
        while (n < 60) begin
            if (rready && !ar_seen) bad++;
            if (arvalid && araddr !== v.addr) bad++;
            if (arvalid && arready) ar_seen = 1'b1;
            if (bk_rdone) begin done = 1'b1; break; end
            tick;
            n++;
        end
        chk("rd_done_seen", 64'(done), 64'd1);
        chk("rd_latency", 64'(n), 64'(3 + v.st_a + v.st_d));
        chk("rd_protocol", 64'(bad), 64'd0);
        chk("rd_data", 64'(bk_rdata), 64'(v.data));
        tick;
        chk("rd_done_single", 64'(bk_rdone), 64'd0);
        chk("rd_rready_low", 64'(rready), 64'd0);
        chk("rd_data_held", 64'(bk_rdata), 64'(v.data));
    endtask

    vec_t wv [4];
    vec_t rv [3];

    initial begin
        int nw, nr, base, k;
        logic both;
        wv[0] = '{12'h010, 32'hDEADBEEF, 4'hF, 0, 0};
        wv[1] = '{12'hABC, 32'h0F0F1234, 4'h5, 5, 4};
        wv[2] = '{12'hFFF, 32'h00000001, 4'h8, 1, 2};
        wv[3] = '{12'h000, 32'hFFFFFFFF, 4'h0, 0, 3};
        rv[0] = '{12'h100, 32'h12345678, 4'h0, 0, 3};
        rv[1] = '{12'hFFC, 32'hCAFEF00D, 4'h0, 4, 0};
        rv[2] = '{12'h001, 32'h00000000, 4'h0, 1, 1};

        rst_n = 1'b0; bk_wstart = 1'b0; bk_rstart = 1'b0;
        bk_waddr = '0; bk_wdata = '0; bk_wstrb = '0; bk_raddr = '0;
        tick; tick;
        chk("rst_valids", 64'({awvalid, wvalid, arvalid, rready}), 64'd0);
        chk("rst_dones", 64'({bk_wdone, bk_rdone, wr_overflow, rd_overflow}), 64'd0);
        chk("rst_payload", 64'({awaddr, araddr, wstrb}), 64'd0);
        chk("rst_data", 64'({wdata, bk_rdata}), 64'd0);
        rst_n = 1'b1;
        tick;

        for (int i = 0; i < 4; i++) do_write(wv[i]);
        for (int i = 0; i < 3; i++) do_read(rv[i]);
        chk("no_overflow", 64'({wr_overflow, rd_overflow}), 64'd0);

        // three back-to-back writes against a slow slave: third is dropped
        aw_st = 3; w_st = 3; base = aw_n;
        for (int i = 0; i < 3; i++) begin
            bk_wstart = 1'b1; bk_waddr = 12'(4 * i); bk_wdata = 32'(4 * i); bk_wstrb = 4'hF;
            tick;
        end
        bk_wstart = 1'b0;
        nw = 0;
        for (int i = 0; i < 60; i++) begin
            if (bk_wdone) nw++;
            tick;
        end
        chk("q_done_count", 64'(nw), 64'd2);
        chk("q_aw_count", 64'(aw_n - base), 64'd2);
        chk("q_first_addr", 64'(aw_log[base % 32]), 64'h0);
        chk("q_second_addr", 64'(aw_log[(base + 1) % 32]), 64'h4);
        chk("q_second_data", 64'(wd_log[(base + 1) % 32]), 64'h4);
        chk("q_wr_overflow", 64'(wr_overflow), 64'd1);
        chk("q_rd_overflow", 64'(rd_overflow), 64'd0);

        // simultaneous write and read
        aw_st = 1; w_st = 1; ar_st = 1; r_st = 1; slv_rdata = 32'h55AA33CC;
        base = ar_n; k = aw_n;
        bk_wstart = 1'b1; bk_waddr = 12'h020; bk_wdata = 32'h0BADF00D; bk_wstrb = 4'h3;
        bk_rstart = 1'b1; bk_raddr = 12'h030;
        tick;
        bk_wstart = 1'b0; bk_rstart = 1'b0;
        both = awvalid && arvalid;
        nw = 0; nr = 0;
        for (int i = 0; i < 40; i++) begin
            if (bk_wdone) nw++;
            if (bk_rdone) nr++;
            tick;
        end
        chk("cc_both_active", 64'(both), 64'd1);
        chk("cc_done_counts", 64'({nw[7:0], nr[7:0]}), 64'h0101);
        chk("cc_rdata", 64'(bk_rdata), 64'h55AA33CC);
        chk("cc_araddr", 64'(ar_log[base % 32]), 64'h030);
        chk("cc_aw_wdata", 64'({aw_log[k % 32], wd_log[k % 32]}), {32'h0, 32'h0BADF00D} | (64'h020 << 32));
        chk("cc_wr_overflow_sticky", 64'(wr_overflow), 64'd1);

        // reset while waiting in R_DATA
        ar_st = 0; r_st = 10; slv_rdata = 32'h11112222;
        bk_rstart = 1'b1; bk_raddr = 12'h044;
        tick;
        bk_rstart = 1'b0;
        k = 0;
        while (!rready && k < 20) begin tick; k++; end
        chk("mr_reached_rdata", 64'(rready), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_async_valids", 64'({arvalid, rready, awvalid, wvalid}), 64'd0);
        chk("mr_async_flags", 64'({bk_rdone, bk_wdone, wr_overflow, rd_overflow}), 64'd0);
        chk("mr_async_data", 64'({bk_rdata, araddr}), 64'd0);
        nr = 0;
        for (int i = 0; i < 3; i++) begin
            tick;
            if (bk_rdone) nr++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            if (bk_rdone || rready || arvalid) nr++;
        end
        chk("mr_no_done", 64'(nr), 64'd0);
        do_read('{12'h044, 32'h600DCAFE, 4'h0, 0, 2});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
